// File: rtl/rv32e_pkg.sv
// rv32e_pkg: shared constants for the RV32E issue stage and the ALU behind it.
//   ALU op codes, RV32I/E opcode/funct3/funct7 values used by the decoder,
//   the architectural register count and the registered issue bundle layout.
package rv32e_pkg;

   localparam int REG_CNT = 16;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_XOR = 3'b100;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  rd;
   } issue_t;

   function automatic logic [31:0] sext12(input logic [11:0] imm);
      return {{20{imm[11]}}, imm};
   endfunction

endpackage

// File: rtl/rv32e_regfile.sv
// rv32e_regfile: 16 x 32-bit register file, x0 hardwired to zero.
//   clk, rst           : clock, async active-high reset (clears x1..x15)
//   raddr1/rdata1      : async read port 1
//   raddr2/rdata2      : async read port 2
//   we/waddr/wdata     : synchronous write port (writes to x0 dropped)
module rv32e_regfile
   import rv32e_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  raddr1,
   output logic [31:0] rdata1,
   input  logic [3:0]  raddr2,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [3:0]  waddr,
   input  logic [31:0] wdata
);

   logic [31:0] mem [REG_CNT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
      end else if (we && waddr != 4'd0) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 4'd0) ? '0 : mem[raddr1];
   assign rdata2 = (raddr2 == 4'd0) ? '0 : mem[raddr2];

endmodule

// File: rtl/rv32e_issue.sv
// rv32e_issue: decode / operand-issue stage feeding rv32e_alu.
//   clk, rst                 : clock, async active-high reset
//   in_valid/in_ready/in_instr : instruction handshake
//   out_valid/out_ready      : issue bundle handshake
//   out_op/out_a/out_b/out_rd : registered ALU bundle
//   wb_valid/wb_rd/wb_data   : ALU write-back into the register file
//   illegal                  : one-cycle pulse after a rejected instruction
module rv32e_issue
   import rv32e_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_op,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [3:0]  out_rd,
   input  logic        wb_valid,
   input  logic [3:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        illegal
);

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd_f, rs1_f, rs2_f;
   logic [3:0]  rd, rs1, rs2;
   logic        is_r, is_i, fn_ok, regs_ok, legal;
   logic [3:0]  dec_op;
   logic [31:0] rf_a, rf_b, src_a, src_b;
   logic [15:0] busy, busy_n, wb_clr, busy_eff;
   logic        hazard, accept, load;
   issue_t      bundle_q;

   assign opcode = in_instr[6:0];
   assign rd_f   = in_instr[11:7];
   assign funct3 = in_instr[14:12];
   assign rs1_f  = in_instr[19:15];
   assign rs2_f  = in_instr[24:20];
   assign funct7 = in_instr[31:25];
   assign rd     = rd_f[3:0];
   assign rs1    = rs1_f[3:0];
   assign rs2    = rs2_f[3:0];

   always_comb begin
      dec_op = ALU_ADD;
      fn_ok  = 1'b0;
      case (funct3)
         F3_ADD: begin dec_op = ALU_ADD; fn_ok = 1'b1; end
         F3_AND: begin dec_op = ALU_AND; fn_ok = 1'b1; end
         F3_OR:  begin dec_op = ALU_OR;  fn_ok = 1'b1; end
         F3_XOR: begin dec_op = ALU_XOR; fn_ok = 1'b1; end
         default: ;
      endcase
      is_r = (opcode == OPC_OP);
      is_i = (opcode == OPC_OP_IMM);
      // funct7 only qualifies register-register forms; SUB is the lone alt encoding
      if (is_r) begin
         if (funct7 == F7_ALT) begin
            if (funct3 == F3_ADD) dec_op = ALU_SUB;
            else                  fn_ok  = 1'b0;
         end else if (funct7 != F7_BASE) begin
            fn_ok = 1'b0;
         end
      end
      regs_ok = !rd_f[4] && !rs1_f[4] && !(is_r && rs2_f[4]);
      legal   = (is_r || is_i) && fn_ok && regs_ok;
   end

   rv32e_regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (rs1),
      .rdata1 (rf_a),
      .raddr2 (rs2),
      .rdata2 (rf_b),
      .we     (wb_valid),
      .waddr  (wb_rd),
      .wdata  (wb_data)
   );

   // Same-cycle write-back bypass; x0 never bypasses since its write is dropped.
   assign src_a = (wb_valid && wb_rd == rs1 && rs1 != 4'd0) ? wb_data : rf_a;
   assign src_b = is_r ? ((wb_valid && wb_rd == rs2 && rs2 != 4'd0) ? wb_data : rf_b)
                       : sext12(in_instr[31:20]);

   always_comb begin
      wb_clr = '0;
      if (wb_valid) wb_clr[wb_rd] = 1'b1;
   end

   // A register being written back this cycle no longer blocks issue.
   assign busy_eff = busy & ~wb_clr;
   assign hazard   = legal && (busy_eff[rs1] || (is_r && busy_eff[rs2]) || busy_eff[rd]);
   assign in_ready = !(out_valid && !out_ready) && !hazard;
   assign accept   = in_valid && in_ready;
   assign load     = accept && legal;

   always_comb begin
      busy_n = busy & ~wb_clr;
      if (load && rd != 4'd0) busy_n[rd] = 1'b1;
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         bundle_q  <= '0;
         illegal   <= 1'b0;
         busy      <= '0;
      end else begin
         illegal <= accept && !legal;
         busy    <= busy_n;
         if (load) begin
            out_valid   <= 1'b1;
            bundle_q.op <= dec_op;
            bundle_q.a  <= src_a;
            bundle_q.b  <= src_b;
            bundle_q.rd <= rd;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign out_op = bundle_q.op;
   assign out_a  = bundle_q.a;
   assign out_b  = bundle_q.b;
   assign out_rd = bundle_q.rd;

endmodule

// File: doc/rv32e_issue.md
# rv32e_issue

Decode/operand-issue stage sitting directly upstream of `rv32e_alu`. It accepts one 32-bit RV32E instruction per handshake and decodes the integer register-register and register-immediate ALU subset. It reads operands from the internal 16-entry register file, tracks outstanding writes with a scoreboard, and presents a registered `{op, a, b, rd}` bundle to the ALU. ALU results return through the write-back port and are written into the register file.

## Interface
Parameters:
- `RESET_PC_UNUSED` — none; the block has no parameters. Register count (16) and data width (32) are fixed by RV32E.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: instruction valid.
- `in_ready` out 1: stage can accept the instruction this cycle.
- `in_instr` in 32: instruction word.
- `out_valid` out 1: issue bundle valid.
- `out_ready` in 1: ALU side accepts the bundle.
- `out_op` out 4: ALU op code.
- `out_a` out 32: operand A (rs1 value).
- `out_b` out 32: operand B (rs2 value, or sign-extended imm[11:0]).
- `out_rd` out 4: destination register.
- `wb_valid` in 1: write-back strobe.
- `wb_rd` in 4: write-back register.
- `wb_data` in 32: write-back data (ALU `result`).
- `illegal` out 1: one-cycle pulse when an accepted instruction is rejected.

## Operation
- **Decoded instructions:**
  - Opcode 0110011 (R-type), funct7 0000000: ADD (f3=000), AND (111), OR (110), XOR (100).
  - Opcode 0110011, funct7 0100000 with f3=000: SUB.
  - Opcode 0010011 (I-type): ADDI, ANDI, ORI, XORI with the same f3 mapping.
- **ALU op codes:** ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100.
- **Illegal instructions:** any other opcode/funct pattern, or bit 4 set in any used rs1/rs2/rd field (x16–x31).
  - The instruction is accepted (consumed), `illegal` pulses the next cycle, and nothing is issued or marked busy.
- **Register file:**
  - x0 reads as 0; writes to x0 are ignored.
  - x1–x15 reset to 0.
  - Write occurs on `wb_valid`.
- **Scoreboard:** a 16-bit `busy` vector; bit 0 is always 0.
  - A bit is set when a bundle with rd≠0 is loaded into the output register.
  - A bit is cleared on `wb_valid` for `wb_rd`.
  - Set and clear of the same bit in the same cycle: set wins.
- **Hazard stall:** `in_ready`=0 when either condition holds:
  - the output register holds a bundle and `out_ready`=0, or
  - the incoming instruction is legal and busy[rs1], busy[rs2] (R-type only) or busy[rd] is set, excluding a bit being cleared by `wb_valid` this same cycle.
- **Write-back bypass:** when `wb_valid` and `wb_rd` equals a source register in the same cycle, the operand is taken from `wb_data`, not the file.
- **Output register:**
  - Loads on `in_valid && in_ready` with a legal instruction.
  - `out_valid` clears on `out_valid && out_ready` with no new load.
  - Load and drain in the same cycle replaces the contents with `out_valid` staying 1.

## Timing
- **Reset values:** `out_valid`=0, `out_op`=0, `out_a`=0, `out_b`=0, `out_rd`=0, `illegal`=0, busy=0, all registers 0.
- **Latency:** 1 cycle from the accepting edge to `out_valid`.
- **Throughput:** 1 instruction/cycle with no hazards and `out_ready`=1.
- **Handshake rules:**
  - Outputs hold stable while `out_valid && !out_ready`.
  - `in_ready` is combinational from `out_valid`, `out_ready`, busy, `wb_*` and `in_instr`.
- **Register-file write:** a write at edge N is visible to reads in cycle N+1. The same-cycle case is handled by the bypass.
- **Reset mid-operation:** the in-flight bundle and busy bits are discarded immediately. Later `wb_valid` strobes for pre-reset rds still write the file but find busy already 0.

## Structure
- `rv32e_pkg`: ALU op localparams, opcode/funct3/funct7 constants, REG_CNT=16. `rv32e_alu` uses the same op localparams.
- Sub-module `rv32e_regfile`: 2 async read ports, 1 sync write port, async-reset storage, x0 hardwired.
- Decode, scoreboard and output register live in `rv32e_issue`.

## Test plan
- **Reset and basic issue:** assert `rst` mid-stream. Then issue ADDI x1,x0,5 → after 1 cycle `out_op`=0000, `out_a`=0, `out_b`=5, `out_rd`=1, and busy[1]=1.
- **Bypass:** with x1 busy, present SUB x2,x1,x1 while `wb_valid`/`wb_rd`=1/`wb_data`=7 in the same cycle → accepted with `out_op`=0001 and a=b=7.
- **RAW stall:** with x3 busy and no write-back, XOR x4,x3,x0 → `in_ready`=0 until `wb_rd`=3 arrives, then it issues.
- **Output backpressure:** hold `out_ready`=0 for 3 cycles → outputs stable, `in_ready`=0; release → next instruction issues in the following cycle.
- **Illegal instructions:**
  - opcode 1100011 → `illegal` pulses once, `out_valid` stays 0, busy unchanged.
  - ADD x17,x1,x2 → illegal.
- **Negative immediate:** ANDI x5,x0,-1 → `out_b`=0xFFFFFFFF. A write-back to x0 with data 9 leaves reads of x0 at 0.
